// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one GCD unit among N requesters.
// One operation is in flight at a time; each result goes back to the requester that issued it.
module gcd_arbiter #(
    parameter  int WL  = 8,
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_val,
    output logic [N-1:0]    req_rdy,
    input  logic [N*WL-1:0] req_a,
    input  logic [N*WL-1:0] req_b,
    output logic [N-1:0]    rsp_val,
    input  logic [N-1:0]    rsp_rdy,
    output logic [WL-1:0]   rsp_data,
    output logic            gcd_ops_val,
    input  logic            gcd_ops_rdy,
    output logic [WL-1:0]   gcd_a,
    output logic [WL-1:0]   gcd_b,
    input  logic            gcd_res_val,
    output logic            gcd_res_rdy,
    input  logic [WL-1:0]   gcd_res,
    output logic            busy,
    output logic [IDW-1:0]  grant_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  win;
    logic            found;
    logic [WL-1:0]   a_q, b_q, res_q;

    // Search starts at ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin : arbitrate
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % 32'(N);
            if (!found && req_val[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nx    = state;
        req_rdy     = '0;
        rsp_val     = '0;
        gcd_ops_val = 1'b0;
        gcd_res_rdy = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_rdy[win] = 1'b1;
                    state_nx     = ISSUE;
                end
            end
            ISSUE: begin
                gcd_ops_val = 1'b1;
                if (gcd_ops_rdy) state_nx = WAIT;
            end
            WAIT: begin
                gcd_res_rdy = 1'b1;
                if (gcd_res_val) state_nx = RESP;
            end
            RESP: begin
                rsp_val[grant_id] = 1'b1;
                if (rsp_rdy[grant_id]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            grant_id <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && found) begin
                a_q      <= req_a[int'(win)*WL +: WL];
                b_q      <= req_b[int'(win)*WL +: WL];
                grant_id <= win;
            end
            if (state == WAIT && gcd_res_val) res_q <= gcd_res;
            // Pointer advances only once the response is taken, not at grant time.
            if (state == RESP && rsp_rdy[grant_id])
                ptr <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign gcd_a    = a_q;
    assign gcd_b    = b_q;
    assign rsp_data = res_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed self-checking bench for gcd_arbiter; the bench also plays the GCD unit.
module tb_gcd_arbiter;

    localparam int WL  = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_val, req_rdy, rsp_val, rsp_rdy;
    logic [N*WL-1:0] req_a, req_b;
    logic [WL-1:0]   rsp_data, gcd_a, gcd_b, gcd_res;
    logic            gcd_ops_val, gcd_ops_rdy, gcd_res_val, gcd_res_rdy, busy;
    logic [IDW-1:0]  grant_id;

    logic ops_block;
    logic res_hold;
    logic pend;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          id;
        int          gid;
        logic [7:0]  data;
    } rsp_t;

    int   grant_q[$];
    rsp_t rsp_q[$];

    gcd_arbiter #(.WL(WL), .N(N)) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
        .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
        .gcd_ops_val(gcd_ops_val), .gcd_ops_rdy(gcd_ops_rdy),
        .gcd_a(gcd_a), .gcd_b(gcd_b),
        .gcd_res_val(gcd_res_val), .gcd_res_rdy(gcd_res_rdy), .gcd_res(gcd_res),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gcd_fn(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // GCD unit stand-in: result is offered one cycle after the operand handshake.
    assign gcd_ops_rdy = ~ops_block;
    always @(posedge clk) begin
        if (rst) begin
            pend        <= 1'b0;
            gcd_res_val <= 1'b0;
            gcd_res     <= '0;
        end else begin
            if (gcd_res_val && gcd_res_rdy) gcd_res_val <= 1'b0;
            else if (pend && !res_hold) begin
                gcd_res_val <= 1'b1;
                pend        <= 1'b0;
            end
            if (gcd_ops_val && gcd_ops_rdy) begin
                pend    <= 1'b1;
                gcd_res <= gcd_fn(gcd_a, gcd_b);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_rdy[i] && req_val[i]) grant_q.push_back(i);
                if (rsp_val[i] && rsp_rdy[i]) rsp_q.push_back('{i, int'(grant_id), rsp_data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*WL +: WL] = a;
        req_b[i*WL +: WL] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        grant_q.delete();
        rsp_q.delete();
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rsp_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        req_val = '0;
        rsp_rdy = '1;
        do_reset();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h want 0", busy); end
        n_checks++; if (rsp_val !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_val got %0h want 0", rsp_val); end
        n_checks++; if (gcd_ops_val !== 1'b0) begin n_fail++; $display("FAIL reset_ops_val got %0h want 0", gcd_ops_val); end
        n_checks++; if (gcd_res_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_res_rdy got %0h want 0", gcd_res_rdy); end
        n_checks++; if ({gcd_a, gcd_b, rsp_data} !== 24'h0) begin n_fail++; $display("FAIL reset_data got %0h want 0", {gcd_a, gcd_b, rsp_data}); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
        n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_req_rdy_idle got %b want 0000", req_rdy); end
        req_val = 4'b0100;
        #1;
        n_checks++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL reset_req_rdy_arb got %b want 0100", req_rdy); end
        req_val = '0;
        tick();
    endtask

    task automatic test_single();
        bit seen;
        do_reset();
        set_op(0, 8'd48, 8'd18);
        req_val = 4'b0001;
        #1;
        n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL single_req_rdy got %b want 0001", req_rdy); end
        tick();
        req_val = '0;
        n_checks++; if (gcd_ops_val !== 1'b1) begin n_fail++; $display("FAIL single_ops_val got %0h want 1", gcd_ops_val); end
        n_checks++; if (gcd_a !== 8'd48 || gcd_b !== 8'd18) begin n_fail++; $display("FAIL single_operands got %0d,%0d want 48,18", gcd_a, gcd_b); end
        tick();
        n_checks++; if (gcd_res_rdy !== 1'b1 || gcd_ops_val !== 1'b0) begin n_fail++; $display("FAIL single_wait got res_rdy=%0h ops_val=%0h want 1,0", gcd_res_rdy, gcd_ops_val); end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (gcd_res_val) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL single_res_timeout got 0 want 1"); end
        tick();
        n_checks++; if (rsp_val !== 4'b0001) begin n_fail++; $display("FAIL single_rsp_val got %b want 0001", rsp_val); end
        n_checks++; if (rsp_data !== 8'd6) begin n_fail++; $display("FAIL single_rsp_data got %0d want 6", rsp_data); end
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got busy=%0h want 0", busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int          exp_id[5]   = '{0, 1, 2, 3, 0};
        logic [7:0]  exp_data[5] = '{8'd6, 8'd7, 8'd27, 8'd25, 8'd6};
        set_op(0, 8'd48, 8'd18);
        set_op(1, 8'd35, 8'd14);
        set_op(2, 8'd81, 8'd27);
        set_op(3, 8'd100, 8'd75);
        req_val = 4'b1111;
        do_reset();
        wait_rsp(5, ok);
        req_val = '0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_timeout got %0d rsps want 5", rsp_q.size()); end
        for (int k = 0; k < 5; k++) begin
            if (ok) begin
                n_checks++; if (grant_q[k] !== exp_id[k]) begin n_fail++; $display("FAIL rr_grant[%0d] got %0d want %0d", k, grant_q[k], exp_id[k]); end
                n_checks++; if (rsp_q[k].id !== exp_id[k] || rsp_q[k].data !== exp_data[k]) begin n_fail++; $display("FAIL rr_rsp[%0d] got id=%0d data=%0d want id=%0d data=%0d", k, rsp_q[k].id, rsp_q[k].data, exp_id[k], exp_data[k]); end
            end
        end
        tick();
    endtask

    task automatic test_fairness();
        bit ok;
        int exp_id[4] = '{0, 2, 0, 2};
        set_op(0, 8'd48, 8'd18);
        set_op(2, 8'd81, 8'd27);
        req_val = 4'b0101;
        do_reset();
        wait_rsp(4, ok);
        req_val = '0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fair_timeout got %0d rsps want 4", rsp_q.size()); end
        for (int k = 0; k < 4; k++) begin
            if (ok) begin
                n_checks++; if (grant_q[k] !== exp_id[k]) begin n_fail++; $display("FAIL fair_grant[%0d] got %0d want %0d", k, grant_q[k], exp_id[k]); end
                n_checks++; if (rsp_q[k].gid !== exp_id[k] || rsp_q[k].id !== exp_id[k]) begin n_fail++; $display("FAIL fair_grant_id[%0d] got gid=%0d id=%0d want %0d", k, rsp_q[k].gid, rsp_q[k].id, exp_id[k]); end
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        ops_block = 1'b1;
        set_op(1, 8'd35, 8'd14);
        set_op(0, 8'd48, 8'd18);
        req_val = 4'b0010;
        tick();
        req_val = '0;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (gcd_ops_val !== 1'b1 || gcd_a !== 8'd35 || gcd_b !== 8'd14) begin n_fail++; $display("FAIL bp_ops_hold[%0d] got val=%0h a=%0d b=%0d want 1,35,14", c, gcd_ops_val, gcd_a, gcd_b); end
            tick();
        end
        // Foreign rsp_rdy bits must not complete requester 1's response.
        rsp_rdy   = 4'b1101;
        ops_block = 1'b0;
        req_val   = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_val != 4'b0000) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_rsp_timeout got 0 want 1"); end
        for (int c = 0; c < 3; c++) begin
            n_checks++; if (rsp_val !== 4'b0010 || rsp_data !== 8'd7) begin n_fail++; $display("FAIL bp_rsp_hold[%0d] got val=%b data=%0d want 0010,7", c, rsp_val, rsp_data); end
            n_checks++; if (req_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_no_grant[%0d] got %b want 0000", c, req_rdy); end
            tick();
        end
        rsp_rdy = 4'b1111;
        tick();
        n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL bp_regrant got %b want 0001", req_rdy); end
        tick();
        req_val = '0;
        wait_rsp(2, ok);
        n_checks++; if (!ok || rsp_q[0].id !== 1 || rsp_q[1].id !== 0 || rsp_q[1].data !== 8'd6) begin n_fail++; $display("FAIL bp_rsp_order got n=%0d want ids 1,0 data 6", rsp_q.size()); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        do_reset();
        res_hold = 1'b1;
        set_op(2, 8'd81, 8'd27);
        req_val = 4'b0100;
        tick();
        req_val = '0;
        tick();
        n_checks++; if (gcd_res_rdy !== 1'b1) begin n_fail++; $display("FAIL rw_in_wait got res_rdy=%0h want 1", gcd_res_rdy); end
        tick();
        set_op(1, 8'd35, 8'd14);
        req_val = 4'b0010;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        res_hold = 1'b0;
        rsp_q.delete();
        n_checks++; if (busy !== 1'b0 || rsp_val !== 4'b0000 || gcd_ops_val !== 1'b0) begin n_fail++; $display("FAIL rw_after_rst got busy=%0h rsp_val=%b ops_val=%0h want 0,0000,0", busy, rsp_val, gcd_ops_val); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rw_grant_id got %0d want 0", grant_id); end
        n_checks++; if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL rw_fresh_grant got %b want 0010", req_rdy); end
        tick();
        req_val = '0;
        wait_rsp(1, ok);
        for (int c = 0; c < 10; c++) tick();
        n_checks++; if (!ok || rsp_q.size() !== 1) begin n_fail++; $display("FAIL rw_rsp_count got %0d want 1", rsp_q.size()); end
        n_checks++; if (ok && (rsp_q[0].id !== 1 || rsp_q[0].data !== 8'd7)) begin n_fail++; $display("FAIL rw_rsp got id=%0d data=%0d want 1,7", rsp_q[0].id, rsp_q[0].data); end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        set_op(3, 8'd100, 8'd75);
        set_op(1, 8'd35, 8'd14);
        req_val = 4'b1000;
        tick();
        req_val = '0;
        wait_rsp(1, ok);
        n_checks++; if (!ok || rsp_q[0].id !== 3) begin n_fail++; $display("FAIL wrap_first got n=%0d want id 3", rsp_q.size()); end
        tick();
        grant_q.delete();
        rsp_q.delete();
        req_val = 4'b1010;
        wait_rsp(2, ok);
        req_val = '0;
        n_checks++; if (!ok || grant_q[0] !== 1 || grant_q[1] !== 3) begin n_fail++; $display("FAIL wrap_order got n=%0d want grants 1,3", grant_q.size()); end
        n_checks++; if (ok && (rsp_q[0].data !== 8'd7 || rsp_q[1].data !== 8'd25)) begin n_fail++; $display("FAIL wrap_data got %0d,%0d want 7,25", rsp_q[0].data, rsp_q[1].data); end
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req_val   = '0;
        rsp_rdy   = '1;
        req_a     = '0;
        req_b     = '0;
        ops_block = 1'b0;
        res_hold  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_backpressure();
        test_reset_in_wait();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
